instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction-memory read interface: holds the PC and drives `instructionAddress`/`read_request`.
- Waits for `readReady`, captures the returned 64-bit `instruction`, and presents it with its PC to decode through a valid/ready handshake.
- Supports PC redirect (branch/jump) and stall via downstream backpressure.
- Sits between the instruction memory and the decode stage.

Parameters:
- RESET_PC, 64'h0, PC loaded on reset; bits [2:0] ignored (forced 0).
- PC_STEP, 8, byte increment per instruction (memory word index = address >> 3).
- TIMEOUT_CYCLES, 16, WAIT-state cycle limit; used only with FETCH_TIMEOUT_EN.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset, sampled on rising clk.
- fetch_enable  input  1  1 = fetch continuously; 0 = finish in-flight fetch, then idle.
- instructionAddress  output  64  byte address to instruction memory.
- read_request  output  1  read strobe to instruction memory.
- instruction  input  64  read data from instruction memory.
- readReady  input  1  memory data-valid indication (level).
- redirect_valid  input  1  1-cycle pulse: load redirect_pc, flush current fetch.
- redirect_pc  input  64  new PC; bits [2:0] forced 0.
- fetched_valid  output  1  fetched_instruction/fetched_pc valid.
- fetched_ready  input  1  decode accepts this cycle.
- fetched_instruction  output  64  captured instruction.
- fetched_pc  output  64  address of fetched_instruction.
- fetch_count  output  32  instructions delivered since reset; wraps at 2^32.
- fetch_error  output  1  sticky timeout flag (FETCH_TIMEOUT_EN only).

Behaviour:
- Reset (reset = 0 at a clk edge):
  - state = IDLE; pc = RESET_PC & ~7.
  - Outputs: instructionAddress = 0, read_request = 0, fetched_valid = 0, fetched_instruction = 0, fetched_pc = 0, fetch_count = 0, fetch_error = 0.
  - Wait counter = 0. Reset overrides everything, including mid-WAIT or mid-DELIVER.
- FSM states: IDLE, ISSUE, WAIT, DELIVER.
  - IDLE: read_request = 0. If fetch_enable = 1, go to ISSUE.
  - ISSUE: read_request = 1, instructionAddress = pc (registered). Go to WAIT unconditionally; this gives one full cycle of address settle, and readReady is ignored in ISSUE.
  - WAIT: read_request = 1, address held. If readReady = 1:
    - fetched_instruction <= instruction, fetched_pc <= pc, fetched_valid <= 1;
    - read_request <= 0; go to DELIVER.
    - Otherwise hold and increment the wait counter.
  - DELIVER: read_request = 0; outputs held stable while fetched_valid = 1 and fetched_ready = 0. On fetched_valid & fetched_ready:
    - fetched_valid <= 0; pc <= pc + PC_STEP (mod 2^64, so 64'hFFFF_FFFF_FFFF_FFF8 wraps to 0); fetch_count++;
    - next state is ISSUE if fetch_enable = 1, else IDLE.
- Latency: from ISSUE to fetched_valid is a minimum of 2 cycles with immediate readReady. Back-to-back throughput is 1 instruction per 3 cycles.
- Redirect (redirect_valid = 1) from any non-reset state:
  - pc <= redirect_pc & ~7; fetched_valid <= 0; read_request <= 0; wait counter cleared;
  - next state is ISSUE if fetch_enable = 1, else IDLE.
  - Redirect has priority over a same-cycle capture or handshake: that instruction is discarded and fetch_count is not incremented.
- fetch_enable dropped during ISSUE/WAIT/DELIVER: the in-flight fetch completes and is delivered; the FSM then goes to IDLE.
- readReady is treated as a level, not an edge; a stale high value is masked by the ISSUE cycle.
- Address out of memory range: returned data (e.g., 0) is delivered unchanged; no special handling.

Optional Feature:
- FETCH_TIMEOUT_EN defined:
  - If WAIT lasts TIMEOUT_CYCLES consecutive cycles without readReady, set fetch_error = 1 (sticky until reset), drop read_request, and go to IDLE.
  - Remain in IDLE while fetch_error = 1, regardless of fetch_enable; redirect updates pc but stays in IDLE.
- Not defined: WAIT persists indefinitely, fetch_error is tied to 0, and no wait counter logic is built.

Test Plan:
- Reset with RESET_PC = 0, fetch_enable = 1; memory returns readReady after 1 cycle, data 64'h95 at every address; fetched_ready = 1 -> fetched_pc sequence 0, 8, 16, 24; fetch_count = 4 after 4 deliveries; instructionAddress matches each PC.
- fetched_ready held 0 for 5 cycles after fetched_valid -> fetched_instruction/fetched_pc stable, read_request = 0, pc unchanged; release -> next request at pc + 8.
- redirect_valid with redirect_pc = 64'h43 during WAIT -> read_request drops, next ISSUE at address 64'h40, no delivery of the flushed fetch, fetch_count unchanged.
- RESET_PC = 64'hFFFF_FFFF_FFFF_FFF8, one delivery -> next instructionAddress = 0.
- fetch_enable = 0 asserted in WAIT -> current instruction delivered, then IDLE with read_request = 0; reset = 0 mid-WAIT -> all outputs 0 on the next cycle.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES = 16, readReady never asserted -> fetch_error = 1 after 16 WAIT cycles, read_request = 0, FSM stays IDLE until reset.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: instruction-memory read initiator feeding the decode stage.
// Holds the PC, issues one read at a time, captures the returned 64-bit word
// and hands it to decode over a valid/ready handshake. Redirects flush the
// fetch in flight and reload the PC.
// Optional build macro: FETCH_TIMEOUT_EN adds a WAIT-state timeout with a
// sticky fetch_error flag; without it WAIT can last indefinitely.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned PC_STEP  = 8
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_enable,
  output logic [63:0] instructionAddress,
  output logic        read_request,
  input  logic [63:0] instruction,
  input  logic        readReady,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        fetched_valid,
  input  logic        fetched_ready,
  output logic [63:0] fetched_instruction,
  output logic [63:0] fetched_pc,
  output logic [31:0] fetch_count,
  output logic        fetch_error
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] WAIT    = 2'd2;
  localparam logic [1:0] DELIVER = 2'd3;

  logic [1:0]  state;
  logic [63:0] pc;
  logic        can_fetch;
  logic        timeout_hit;

`ifdef FETCH_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] wait_cnt;

  // A latched error blocks any new fetch until reset.
  assign can_fetch   = fetch_enable && !fetch_error;
  assign timeout_hit = (state == WAIT) && !readReady &&
                       (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

  // Count consecutive unanswered WAIT cycles and latch the error on the last one.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt    <= '0;
      fetch_error <= 1'b0;
    end else if (redirect_valid) begin
      wait_cnt <= '0;
    end else if (state == WAIT && !readReady) begin
      if (timeout_hit) begin
        wait_cnt    <= '0;
        fetch_error <= 1'b1;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  assign can_fetch   = fetch_enable;
  assign timeout_hit = 1'b0;
  assign fetch_error = 1'b0;
`endif

  // Fetch FSM: redirect wins over any same-cycle capture or handshake.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state               <= IDLE;
      pc                  <= RESET_PC & ~64'h7;
      instructionAddress  <= 64'h0;
      read_request        <= 1'b0;
      fetched_valid       <= 1'b0;
      fetched_instruction <= 64'h0;
      fetched_pc          <= 64'h0;
      fetch_count         <= 32'h0;
    end else if (redirect_valid) begin
      pc            <= redirect_pc & ~64'h7;
      fetched_valid <= 1'b0;
      read_request  <= 1'b0;
      state         <= can_fetch ? ISSUE : IDLE;
    end else begin
      case (state)
        IDLE: begin
          read_request <= 1'b0;
          if (can_fetch) begin
            state <= ISSUE;
          end
        end
        ISSUE: begin
          read_request       <= 1'b1;
          instructionAddress <= pc;
          state              <= WAIT;
        end
        WAIT: begin
          if (readReady) begin
            fetched_instruction <= instruction;
            fetched_pc          <= pc;
            fetched_valid       <= 1'b1;
            read_request        <= 1'b0;
            state               <= DELIVER;
          end else if (timeout_hit) begin
            read_request <= 1'b0;
            state        <= IDLE;
          end
        end
        DELIVER: begin
          if (fetched_valid && fetched_ready) begin
            fetched_valid <= 1'b0;
            pc            <= pc + 64'(PC_STEP);
            fetch_count   <= fetch_count + 32'd1;
            state         <= can_fetch ? ISSUE : IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed cycle table, hand-written reset/timeout
// sequences and a randomized run against a transaction-level scoreboard.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        reset;
  logic        fetch_enable;
  logic [63:0] instructionAddress;
  logic        read_request;
  logic [63:0] instruction;
  logic        readReady;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        fetched_valid;
  logic        fetched_ready;
  logic [63:0] fetched_instruction;
  logic [63:0] fetched_pc;
  logic [31:0] fetch_count;
  logic        fetch_error;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        fe;
    logic        fr;
    logic        rv;
    logic [63:0] rpc;
    logic        rr;
    logic [63:0] ins;
    logic        rq;
    logic [63:0] addr;
    logic        fv;
    logic [63:0] fpc;
    logic [63:0] fins;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];

  instruction_fetch_unit dut (
    .clk                 (clk),
    .reset               (reset),
    .fetch_enable        (fetch_enable),
    .instructionAddress  (instructionAddress),
    .read_request        (read_request),
    .instruction         (instruction),
    .readReady           (readReady),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .fetched_valid       (fetched_valid),
    .fetched_ready       (fetched_ready),
    .fetched_instruction (fetched_instruction),
    .fetched_pc          (fetched_pc),
    .fetch_count         (fetch_count),
    .fetch_error         (fetch_error)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic fe, input logic fr, input logic rv,
                              input logic [63:0] rpc, input logic rr,
                              input logic [63:0] ins, input logic rq,
                              input logic [63:0] addr, input logic fv,
                              input logic [63:0] fpc, input logic [63:0] fins,
                              input logic [31:0] cnt);
    vec_t v;
    v.fe = fe; v.fr = fr; v.rv = rv; v.rpc = rpc; v.rr = rr; v.ins = ins;
    v.rq = rq; v.addr = addr; v.fv = fv; v.fpc = fpc; v.fins = fins; v.cnt = cnt;
    return v;
  endfunction

  // Memory contents: every address holds a distinct, address-derived word.
  function automatic logic [63:0] memf(input logic [63:0] a);
    return {a[31:0], a[63:32]} ^ 64'hC3A5_5A3C_0F1E_2D4B;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", tag, act, exp_v);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    fetch_enable   = v.fe;
    fetched_ready  = v.fr;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    readReady      = v.rr;
    instruction    = v.ins;
  endtask

  // Hold reset for two edges, check every output is cleared, then release.
  task automatic doReset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    fetch_enable = 1'b0; fetched_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 64'h0; readReady = 1'b0; instruction = 64'h0;
    @(posedge clk);
    #1;
    checkOutput({tag, "_rq"},    64'(read_request), 64'h0);
    checkOutput({tag, "_addr"},  instructionAddress, 64'h0);
    checkOutput({tag, "_fv"},    64'(fetched_valid), 64'h0);
    checkOutput({tag, "_fpc"},   fetched_pc, 64'h0);
    checkOutput({tag, "_fins"},  fetched_instruction, 64'h0);
    checkOutput({tag, "_cnt"},   64'(fetch_count), 64'h0);
    checkOutput({tag, "_err"},   64'(fetch_error), 64'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [63:0] exp_pc;
    logic [31:0] exp_cnt;
    int          req_age;
    int          lat;

    reset = 1'b0; fetch_enable = 1'b0; fetched_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 64'h0; readReady = 1'b0;
    instruction = 64'h0;

    //          fe fr rv rpc                     rr ins        rq addr                    fv fpc                     fins       cnt
    vecs.push_back(mk(1, 1, 0, 64'h0,            0, 64'h0,     0, 64'h0,                  0, 64'h0,                  64'h0,     0)); // 0 IDLE->ISSUE
    vecs.push_back(mk(1, 1, 0, 64'h0,            1, 64'h77,    1, 64'h0,                  0, 64'h0,                  64'h0,     0)); // 1 stale readReady masked
    vecs.push_back(mk(1, 1, 0, 64'h0,            1, 64'h95,    0, 64'h0,                  1, 64'h0,                  64'h95,    0)); // 2 capture
    vecs.push_back(mk(1, 0, 0, 64'h0,            0, 64'h0,     0, 64'h0,                  1, 64'h0,                  64'h95,    0)); // 3 stall
    vecs.push_back(mk(1, 1, 0, 64'h0,            0, 64'h0,     0, 64'h0,                  0, 64'h0,                  64'h95,    1)); // 4 handshake
    vecs.push_back(mk(1, 1, 0, 64'h0,            0, 64'h0,     1, 64'h8,                  0, 64'h0,                  64'h95,    1)); // 5 issue pc 8
    vecs.push_back(mk(1, 1, 0, 64'h0,            0, 64'h0,     1, 64'h8,                  0, 64'h0,                  64'h95,    1)); // 6 wait
    vecs.push_back(mk(1, 1, 0, 64'h0,            1, 64'h1234,  0, 64'h8,                  1, 64'h8,                  64'h1234,  1)); // 7 capture
    vecs.push_back(mk(0, 1, 0, 64'h0,            0, 64'h0,     0, 64'h8,                  0, 64'h8,                  64'h1234,  2)); // 8 deliver -> IDLE
    vecs.push_back(mk(0, 1, 0, 64'h0,            0, 64'h0,     0, 64'h8,                  0, 64'h8,                  64'h1234,  2)); // 9 idle
    vecs.push_back(mk(0, 1, 1, 64'h43,           0, 64'h0,     0, 64'h8,                  0, 64'h8,                  64'h1234,  2)); // 10 redirect in IDLE
    vecs.push_back(mk(1, 1, 0, 64'h0,            0, 64'h0,     0, 64'h8,                  0, 64'h8,                  64'h1234,  2)); // 11 -> ISSUE
    vecs.push_back(mk(1, 1, 0, 64'h0,            0, 64'h0,     1, 64'h40,                 0, 64'h8,                  64'h1234,  2)); // 12 issue 0x40
    vecs.push_back(mk(1, 1, 1, 64'h100,          1, 64'hDEAD,  0, 64'h40,                 0, 64'h8,                  64'h1234,  2)); // 13 redirect beats capture
    vecs.push_back(mk(1, 1, 0, 64'h0,            0, 64'h0,     1, 64'h100,                0, 64'h8,                  64'h1234,  2)); // 14 issue 0x100
    vecs.push_back(mk(1, 1, 0, 64'h0,            1, 64'hAB,    0, 64'h100,                1, 64'h100,                64'hAB,    2)); // 15 capture
    vecs.push_back(mk(1, 1, 1, 64'h200,          0, 64'h0,     0, 64'h100,                0, 64'h100,                64'hAB,    2)); // 16 redirect beats handshake
    vecs.push_back(mk(1, 1, 0, 64'h0,            0, 64'h0,     1, 64'h200,                0, 64'h100,                64'hAB,    2)); // 17 issue 0x200
    vecs.push_back(mk(0, 1, 0, 64'h0,            0, 64'h0,     1, 64'h200,                0, 64'h100,                64'hAB,    2)); // 18 enable dropped in WAIT
    vecs.push_back(mk(0, 1, 0, 64'h0,            1, 64'hCC,    0, 64'h200,                1, 64'h200,                64'hCC,    2)); // 19 still captured
    vecs.push_back(mk(0, 1, 0, 64'h0,            0, 64'h0,     0, 64'h200,                0, 64'h200,                64'hCC,    3)); // 20 delivered -> IDLE
    vecs.push_back(mk(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h0, 0, 64'h200,            0, 64'h200,                64'hCC,    3)); // 21 redirect to top
    vecs.push_back(mk(1, 1, 0, 64'h0,            0, 64'h0,     0, 64'h200,                0, 64'h200,                64'hCC,    3)); // 22 -> ISSUE
    vecs.push_back(mk(1, 1, 0, 64'h0,            0, 64'h0,     1, 64'hFFFF_FFFF_FFFF_FFF8, 0, 64'h200,               64'hCC,    3)); // 23 issue top
    vecs.push_back(mk(1, 1, 0, 64'h0,            1, 64'h0,     0, 64'hFFFF_FFFF_FFFF_FFF8, 1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0,   3)); // 24 capture zero data
    vecs.push_back(mk(1, 1, 0, 64'h0,            0, 64'h0,     0, 64'hFFFF_FFFF_FFFF_FFF8, 0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0,   4)); // 25 handshake
    vecs.push_back(mk(1, 1, 0, 64'h0,            0, 64'h0,     1, 64'h0,                  0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0,    4)); // 26 PC wrapped
    vecs.push_back(mk(1, 1, 0, 64'h0,            1, 64'h95,    0, 64'h0,                  1, 64'h0,                  64'h95,    4)); // 27 capture
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(1, 0, 0, 64'h0, (k == 2), 64'h5555,    0, 64'h0,                  1, 64'h0,                  64'h95,    4)); // 28-32 backpressure
    vecs.push_back(mk(1, 1, 0, 64'h0,            0, 64'h0,     0, 64'h0,                  0, 64'h0,                  64'h95,    5)); // 33 release
    vecs.push_back(mk(1, 1, 0, 64'h0,            0, 64'h0,     1, 64'h8,                  0, 64'h0,                  64'h95,    5)); // 34 next request pc+8

    doReset("reset0");

    // Directed cycle table.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkOutput($sformatf("row%0d_rq", i),   64'(read_request), 64'(vecs[i].rq));
      checkOutput($sformatf("row%0d_addr", i), instructionAddress, vecs[i].addr);
      checkOutput($sformatf("row%0d_fv", i),   64'(fetched_valid), 64'(vecs[i].fv));
      checkOutput($sformatf("row%0d_fpc", i),  fetched_pc, vecs[i].fpc);
      checkOutput($sformatf("row%0d_fins", i), fetched_instruction, vecs[i].fins);
      checkOutput($sformatf("row%0d_cnt", i),  64'(fetch_count), 64'(vecs[i].cnt));
      checkOutput($sformatf("row%0d_err", i),  64'(fetch_error), 64'h0);
    end

    // The table ends mid-WAIT: reset there must clear everything.
    doReset("reset_midwait");

    // Randomized run against a transaction-level scoreboard.
    exp_pc  = 64'h0;
    exp_cnt = 32'h0;
    req_age = 0;
    lat     = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      checkOutput("rnd_count", 64'(fetch_count), 64'(exp_cnt));
      checkOutput("rnd_err", 64'(fetch_error), 64'h0);
      if (read_request)
        checkOutput("rnd_addr", instructionAddress, exp_pc);
      if (fetched_valid) begin
        checkOutput("rnd_fpc", fetched_pc, exp_pc);
        checkOutput("rnd_fins", fetched_instruction, memf(exp_pc));
      end
      fetch_enable   = ($urandom_range(7) != 0);
      fetched_ready  = ($urandom_range(3) != 0);
      redirect_valid = ($urandom_range(39) == 0);
      redirect_pc    = {$urandom, $urandom};
      if (read_request) begin
        if (req_age == 0)
          lat = $urandom_range(3);
        readReady = (req_age >= lat);
        req_age++;
      end else begin
        req_age   = 0;
        readReady = ($urandom_range(4) == 0);
      end
      instruction = memf(instructionAddress);
      if (redirect_valid) begin
        exp_pc = redirect_pc & ~64'h7;
      end else if (fetched_valid && fetched_ready) begin
        exp_pc  = exp_pc + 64'd8;
        exp_cnt = exp_cnt + 32'd1;
      end
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    checkOutput("rnd_final_count", 64'(fetch_count), 64'(exp_cnt));
    checkOutput("rnd_progress", 64'(exp_cnt >= 32'd50), 64'h1);

`ifdef FETCH_TIMEOUT_EN
    // Memory never answers: the fetch must time out and then stay parked.
    doReset("reset_timeout");
    @(negedge clk);
    fetch_enable = 1'b1; fetched_ready = 1'b1; readReady = 1'b0;
    repeat (24) @(posedge clk);
    #1;
    checkOutput("to_err", 64'(fetch_error), 64'h1);
    checkOutput("to_rq", 64'(read_request), 64'h0);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 64'h80;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput($sformatf("to_idle%0d_rq", k), 64'(read_request), 64'h0);
      checkOutput($sformatf("to_idle%0d_err", k), 64'(fetch_error), 64'h1);
    end
    doReset("reset_after_timeout");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
